// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - two-port round-robin arbiter in front of a single-port dmem syncram
// Optional burst locking (lock0/lock1 ports, owner tracking) is enabled by defining DMEM_ARB_LOCK_EN.
module dmem_arbiter #(
    parameter int ADDR_W    = 12,
    parameter int DATA_W    = 32,
    parameter int MAX_BURST = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
`ifdef DMEM_ARB_LOCK_EN
    input  logic              lock0,
    input  logic              lock1,
`endif
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    input  logic [DATA_W-1:0] mem_q
);

    if (MAX_BURST < 1) begin : g_bad_cfg
        $error("dmem_arbiter: MAX_BURST must be at least 1");
    end

    logic              last_gnt;
    logic [1:0]        rv_q;
    logic [DATA_W-1:0] hold0;
    logic [DATA_W-1:0] hold1;
    logic              pick1;

`ifdef DMEM_ARB_LOCK_EN
    localparam int CNT_W = $clog2(MAX_BURST + 1);

    logic             owner_valid;
    logic             owner;
    logic [CNT_W-1:0] burst_cnt;
    logic             owner_req;
    logic             owner_lock;
    logic             owner_holds;
    logic             lock_grant;

    assign owner_req   = owner ? req1 : req0;
    assign owner_lock  = owner ? lock1 : lock0;
    // The owner keeps winning conflicts only until it has used up its burst allowance.
    assign owner_holds = owner_valid && owner_req && owner_lock
                         && (burst_cnt < CNT_W'(MAX_BURST));
    assign pick1       = owner_holds ? owner : ~last_gnt;
    assign lock_grant  = (gnt0 & lock0) | (gnt1 & lock1);

    // Any cycle without a locked grant (lock drop, idle owner) releases ownership.
    always_ff @(posedge clock) begin
        if (reset) begin
            owner_valid <= 1'b0;
            owner       <= 1'b0;
            burst_cnt   <= '0;
        end else if (lock_grant) begin
            if (owner_valid && (owner == gnt1)) begin
                if (burst_cnt != CNT_W'(MAX_BURST)) begin
                    burst_cnt <= burst_cnt + CNT_W'(1);
                end
            end else begin
                owner_valid <= 1'b1;
                owner       <= gnt1;
                burst_cnt   <= CNT_W'(1);
            end
        end else begin
            owner_valid <= 1'b0;
            burst_cnt   <= '0;
        end
    end
`else
    assign pick1 = ~last_gnt;
`endif

    // Grants are combinational so the winner reaches the syncram in the request cycle.
    assign gnt0 = ~reset & req0 & (~req1 | ~pick1);
    assign gnt1 = ~reset & req1 & (~req0 | pick1);

    assign mem_address = gnt1 ? addr1 : addr0;
    assign mem_data    = gnt1 ? wdata1 : wdata0;
    assign mem_wren    = (gnt0 & we0) | (gnt1 & we1);

    // mem_q is only meaningful in the cycle after the read; the hold regs keep it afterwards.
    assign rvalid0 = rv_q[0] & ~reset;
    assign rvalid1 = rv_q[1] & ~reset;
    assign rdata0  = reset ? '0 : (rv_q[0] ? mem_q : hold0);
    assign rdata1  = reset ? '0 : (rv_q[1] ? mem_q : hold1);

    always_ff @(posedge clock) begin
        if (reset) begin
            last_gnt <= 1'b1;
            rv_q     <= 2'b00;
            hold0    <= '0;
            hold1    <= '0;
        end else begin
            if (gnt0 | gnt1) begin
                last_gnt <= gnt1;
            end
            rv_q <= {gnt1 & ~we1, gnt0 & ~we0};
            if (rv_q[0]) begin
                hold0 <= mem_q;
            end
            if (rv_q[1]) begin
                hold1 <= mem_q;
            end
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - self-checking bench for dmem_arbiter with a behavioural model and syncram
module tb_dmem_arbiter;

    localparam int ADDR_W    = 12;
    localparam int DATA_W    = 32;
    localparam int MAX_BURST = 8;
    localparam int DEPTH     = 1 << ADDR_W;

    logic              clock = 1'b0;
    logic              reset;
    logic              req0, req1, we0, we1;
    logic [ADDR_W-1:0] addr0, addr1;
    logic [DATA_W-1:0] wdata0, wdata1;
`ifdef DMEM_ARB_LOCK_EN
    logic              lock0, lock1;
`endif
    logic              gnt0, gnt1, rvalid0, rvalid1, mem_wren;
    logic [DATA_W-1:0] rdata0, rdata1, mem_data, mem_q;
    logic [ADDR_W-1:0] mem_address;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
        .clock(clock), .reset(reset),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
`ifdef DMEM_ARB_LOCK_EN
        .lock0(lock0), .lock1(lock1),
`endif
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rdata0(rdata0), .rdata1(rdata1),
        .mem_address(mem_address), .mem_data(mem_data), .mem_wren(mem_wren), .mem_q(mem_q)
    );

    always #5 clock = ~clock;

    function automatic logic [DATA_W-1:0] init_word(input int a);
        if (a == 'h010) return 32'hDEADBEEF;
        return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    // Syncram: registered read of the presented address, write when mem_wren.
    logic [DATA_W-1:0] mem   [DEPTH];
    bit                mem_w [DEPTH];
    always @(posedge clock) begin
        mem_q <= mem_w[mem_address] ? mem[mem_address] : init_word(int'(mem_address));
        if (mem_wren) begin
            mem[mem_address]   <= mem_data;
            mem_w[mem_address] <= 1'b1;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: memory contents, last winner, pending read results, held data.
    logic [DATA_W-1:0] mref   [DEPTH];
    bit                mref_w [DEPTH];
    bit                m_last;
    bit                m_rv [2];
    logic [DATA_W-1:0] m_rd [2];
    logic [DATA_W-1:0] m_hold [2];
    int                m_own;
    int                m_run;
    bit                started = 0;

    function automatic logic [DATA_W-1:0] mval(input int a);
        return mref_w[a] ? mref[a] : init_word(a);
    endfunction

    always @(negedge clock) begin
        bit e0, e1, w1, own_holds;
        if (reset) begin
            chk("rst_gnt0", gnt0, 0);       chk("rst_gnt1", gnt1, 0);
            chk("rst_wren", mem_wren, 0);
            chk("rst_rvalid0", rvalid0, 0); chk("rst_rvalid1", rvalid1, 0);
            chk("rst_rdata0", rdata0, 0);   chk("rst_rdata1", rdata1, 0);
            m_last = 1; m_rv[0] = 0; m_rv[1] = 0;
            m_hold[0] = '0; m_hold[1] = '0;
            m_own = -1; m_run = 0;
            started = 1;
        end else if (started) begin
            own_holds = 0;
`ifdef DMEM_ARB_LOCK_EN
            if (m_own == 0) own_holds = req0 && lock0 && (m_run < MAX_BURST);
            if (m_own == 1) own_holds = req1 && lock1 && (m_run < MAX_BURST);
`endif
            if (req0 && req1) begin
                w1 = own_holds ? (m_own == 1) : !m_last;
                e0 = !w1; e1 = w1;
            end else begin
                e0 = req0; e1 = req1;
            end
            chk("gnt0", gnt0, e0);
            chk("gnt1", gnt1, e1);
            chk("mem_wren", mem_wren, (e0 && we0) || (e1 && we1));
            if (e0 || e1) begin
                chk("mem_address", mem_address, e1 ? addr1 : addr0);
                chk("mem_data", mem_data, e1 ? wdata1 : wdata0);
            end
            chk("rvalid0", rvalid0, m_rv[0]);
            chk("rvalid1", rvalid1, m_rv[1]);
            chk("rdata0", rdata0, m_rv[0] ? m_rd[0] : m_hold[0]);
            chk("rdata1", rdata1, m_rv[1] ? m_rd[1] : m_hold[1]);
            for (int p = 0; p < 2; p++) if (m_rv[p]) m_hold[p] = m_rd[p];
            m_rv[0] = e0 && !we0;
            m_rv[1] = e1 && !we1;
            if (m_rv[0]) m_rd[0] = mval(int'(addr0));
            if (m_rv[1]) m_rd[1] = mval(int'(addr1));
            if (e0 && we0) begin mref[addr0] = wdata0; mref_w[addr0] = 1; end
            if (e1 && we1) begin mref[addr1] = wdata1; mref_w[addr1] = 1; end
            if (e0 || e1) m_last = e1;
`ifdef DMEM_ARB_LOCK_EN
            // Run length of consecutive locked grants to the same port, capped at MAX_BURST.
            if ((e0 && lock0) || (e1 && lock1)) begin
                if (m_own == int'(e1)) m_run = (m_run < MAX_BURST) ? m_run + 1 : m_run;
                else begin m_own = int'(e1); m_run = 1; end
            end else begin
                m_own = -1; m_run = 0;
            end
`endif
        end
    end

    task automatic gen(output logic r, output logic w, output logic [ADDR_W-1:0] a,
                       output logic [DATA_W-1:0] d);
        r = ($urandom_range(0, 3) != 0);
        w = ($urandom_range(0, 2) == 0);
        a = ADDR_W'($urandom_range(0, 31));
        d = $urandom;
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic g0, g1;
        reset = 1; req0 = 1; we0 = 0; addr0 = 'h010; wdata0 = '0;
        req1 = 0; we1 = 0; addr1 = '0; wdata1 = '0;
`ifdef DMEM_ARB_LOCK_EN
        lock0 = 0; lock1 = 0;
`endif
        // Reset state with a request pending: nothing granted, outputs cleared.
        @(negedge clock);
        chk("lit_rst_gnt0", gnt0, 0);
        chk("lit_rst_rdata0", rdata0, 0);
        cyc();
        cyc(); reset = 0;
        @(negedge clock);
        chk("lit_rd_gnt0", gnt0, 1);
        chk("lit_rd_addr", mem_address, 'h010);
        cyc(); req0 = 0;
        @(negedge clock);
        chk("lit_rd_rvalid0", rvalid0, 1);
        chk("lit_rd_rdata0", rdata0, 32'hDEADBEEF);
        chk("lit_rd_rvalid1", rvalid1, 0);

        // Lone write from port 1, then read it back through port 0.
        cyc(); req1 = 1; we1 = 1; addr1 = 'h0FF; wdata1 = 32'h12345678;
        @(negedge clock);
        chk("lit_wr_gnt1", gnt1, 1);
        chk("lit_wr_wren", mem_wren, 1);
        chk("lit_wr_addr", mem_address, 'h0FF);
        chk("lit_wr_data", mem_data, 32'h12345678);
        cyc(); req1 = 0; we1 = 0; req0 = 1; addr0 = 'h0FF;
        @(negedge clock);
        chk("lit_wr_no_rvalid1", rvalid1, 0);
        chk("lit_rb_gnt0", gnt0, 1);
        cyc(); req0 = 0;
        @(negedge clock);
        chk("lit_rb_rdata0", rdata0, 32'h12345678);

        // Read granted, then reset lands in the rvalid cycle.
        cyc(); req0 = 1; addr0 = 'h010;
        @(negedge clock);
        chk("lit_rr_gnt0", gnt0, 1);
        cyc(); reset = 1; req1 = 1; addr1 = 'h020;
        @(negedge clock);
        chk("lit_rr_rvalid0", rvalid0, 0);
        chk("lit_rr_rdata0", rdata0, 0);
        chk("lit_rr_gnt0b", gnt0, 0);
        chk("lit_rr_gnt1", gnt1, 0);
        cyc();
        cyc(); reset = 0;

        // Continuous conflict after reset: strict alternation starting with port 0.
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            chk("lit_alt_gnt0", gnt0, (k % 2) == 0);
            chk("lit_alt_gnt1", gnt1, (k % 2) == 1);
            cyc();
        end

        // Burst stimulus: prime last winner = 0, then port 1 (locked when enabled) vs port 0.
        req0 = 0; req1 = 0; reset = 1;
        cyc(); reset = 0; req0 = 1;
        @(negedge clock);
        chk("lit_prime_gnt0", gnt0, 1);
        cyc(); req1 = 1;
`ifdef DMEM_ARB_LOCK_EN
        lock1 = 1;
`endif
        for (int k = 0; k < 10; k++) begin
            bit exp1;
`ifdef DMEM_ARB_LOCK_EN
            exp1 = (k < MAX_BURST) || (k > MAX_BURST);
`else
            exp1 = (k % 2) == 0;
`endif
            @(negedge clock);
            chk("lit_burst_gnt1", gnt1, exp1);
            chk("lit_burst_gnt0", gnt0, !exp1);
            cyc();
        end
        req0 = 0; req1 = 0;
`ifdef DMEM_ARB_LOCK_EN
        lock1 = 0;
`endif

        // Randomized traffic: requests held until granted, occasional reset pulses.
        for (int i = 0; i < 3000; i++) begin
            @(negedge clock);
            g0 = gnt0; g1 = gnt1;
            cyc();
            if (reset) reset = 0;
            else if ($urandom_range(0, 99) == 0) reset = 1;
            if (!req0 || g0) begin
                gen(req0, we0, addr0, wdata0);
`ifdef DMEM_ARB_LOCK_EN
                lock0 = ($urandom_range(0, 2) != 0);
`endif
            end
            if (!req1 || g1) begin
                gen(req1, we1, addr1, wdata1);
`ifdef DMEM_ARB_LOCK_EN
                lock1 = ($urandom_range(0, 2) != 0);
`endif
            end
        end
        @(negedge clock);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 12, dmem word-address width.
REQ-002 SHALL have parameter DATA_W, default 32, dmem data width.
REQ-003 SHALL have parameter MAX_BURST, default 8, maximum consecutive locked grants per owner.
REQ-004 SHALL have port clock, input, 1, the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset, input, 1, synchronous, active-high reset.
REQ-006 SHALL have ports req0/req1, input, 1 each, access request from port 0 (processor) and port 1 (loader/debug).
REQ-007 SHALL have ports we0/we1, input, 1 each, 1 = write, 0 = read.
REQ-008 SHALL have ports addr0/addr1, input, ADDR_W each, word address.
REQ-009 SHALL have ports wdata0/wdata1, input, DATA_W each, write data.
REQ-010 SHALL have ports lock0/lock1, input, 1 each, burst-hold request; present only under the macro in REQ-031.
REQ-011 SHALL have ports gnt0/gnt1, output, 1 each, access accepted this cycle.
REQ-012 SHALL have ports rvalid0/rvalid1, output, 1 each, read data valid.
REQ-013 SHALL have ports rdata0/rdata1, output, DATA_W each, read data.
REQ-014 SHALL have ports mem_address (output, ADDR_W), mem_data (output, DATA_W), mem_wren (output, 1), mem_q (input, DATA_W), connecting to the single-port dmem syncram.

Function
REQ-015 SHALL grant at most one port per cycle; gnt0 and gnt1 are never both 1.
REQ-016 SHALL compute gnt combinationally from req and registered state in the same cycle the request is presented.
REQ-017 SHALL drive mem_address, mem_data and mem_wren from the granted port in the grant cycle; mem_wren = weX AND gntX; mem_wren = 0 with no grant.
REQ-018 SHALL hold the requester's req/we/addr/wdata stable until it sees gnt; a request without gnt is retried unchanged.
REQ-019 SHALL, for a granted read in cycle N, assert rvalidX for exactly one cycle in N+1 with rdataX = mem_q; writes never assert rvalid.
REQ-020 SHALL hold rdataX at its last value when rvalidX = 0.
REQ-021 SHALL allow back-to-back grants every cycle, including a read to one port in N and a grant to the other port in N+1.
REQ-022 SHALL arbitrate round-robin: 1-bit pointer last_gnt; on conflict the port other than last_gnt wins; last_gnt updates at the edge ending each grant cycle.
REQ-023 SHALL grant the sole requester immediately, regardless of last_gnt.
REQ-024 SHALL keep state: last_gnt, rvalid pipeline regs (2 bits), and under the macro an owner flag plus burst counter.

Reset
REQ-025 SHALL, while reset = 1 at a rising edge, clear gnt0/gnt1, rvalid0/rvalid1, mem_wren to 0, and rdata0/rdata1 to 0.
REQ-026 SHALL set last_gnt = 1 on reset so port 0 wins the first conflict.
REQ-027 SHALL drop any read whose rvalid would fall in the cycle after reset; no rvalid in the first post-reset cycle.
REQ-028 SHALL suppress all grants and mem_wren in any cycle where reset = 1.

Configuration
REQ-029 Macro DMEM_ARB_LOCK_EN SHALL control burst locking.
REQ-030 Without DMEM_ARB_LOCK_EN: lock0/lock1 absent; pure round-robin per REQ-022.
REQ-031 With DMEM_ARB_LOCK_EN: a port granted with lockX = 1 becomes owner; while owner keeps lockX = 1 and reqX = 1 it wins conflicts, until MAX_BURST consecutive grants, after which the other port wins the next conflict.
REQ-032 With DMEM_ARB_LOCK_EN: counter resets to 0 on owner lock drop, owner idle cycle, or ownership change; counter saturates at MAX_BURST.

Verification
REQ-033 Reset, then req0 read addr 0x010 (mem holds 0xDEADBEEF) -> gnt0 same cycle, rvalid0 = 1 and rdata0 = 0xDEADBEEF next cycle, rvalid1 = 0.
REQ-034 req0 and req1 both asserted continuously, reads -> grants alternate 0,1,0,1 starting with port 0; never simultaneous.
REQ-035 req1 write addr 0x0FF data 0x12345678 alone -> gnt1, mem_wren = 1, mem_address = 0x0FF, mem_data = 0x12345678 that cycle; no rvalid1; later read of 0x0FF returns 0x12345678.
REQ-036 Read granted to port 0 in cycle N, reset asserted in N+1 -> rvalid0 = 0, rdata0 = 0, no grants that cycle.
REQ-037 With DMEM_ARB_LOCK_EN, MAX_BURST = 8: port 1 lock1 = 1 and req1 held, port 0 requesting -> 8 consecutive gnt1, then gnt0 on the 9th conflict cycle.
REQ-038 Without DMEM_ARB_LOCK_EN, same stimulus minus lock -> strict alternation per REQ-034.
